// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: walks an inclusive memory range via the consistency port and streams each word as 8N1 UART frames, LSB byte first.
module mem_dump_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  uart_clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [ADDR_BITS-1:0]  end_addr,
  output logic                  con_rd,
  output logic [ADDR_BITS-1:0]  con_addr,
  input  logic [WORD_WIDTH-1:0] con_out,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_BITS:0]    words_sent
);
  localparam int NB = WORD_WIDTH / 8;
  localparam int BB = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, end_q, end_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_q, bit_d;
  logic [BB-1:0]         byte_q, byte_d;
  logic [ADDR_BITS:0]    words_q, words_d;
  logic                  aborted_q, aborted_d, pend_q, pend_d, tx_q, tx_d, last;
  logic [7:0]            cur_byte;
  logic [2:0]            bsel;
  assign last       = byte_q == BB'(NB - 1);
  assign con_rd     = state_q == READ;
  assign con_addr   = addr_q;
  assign busy       = state_q == READ || state_q == CAPTURE || state_q == SEND;
  assign done       = state_q == DONE;
  assign aborted    = aborted_q;
  assign words_sent = words_q;
  assign tx         = tx_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    words_d   = words_q;
    aborted_d = aborted_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = READ;
        addr_d    = start_addr;
        end_d     = end_addr;
        words_d   = '0;
        aborted_d = 1'b0;
        pend_d    = 1'b0;
      end
      READ: begin
        state_d   = abort ? DONE : CAPTURE;
        aborted_d = aborted_q | abort;
      end
      CAPTURE: if (abort) begin
        state_d   = DONE;
        aborted_d = 1'b1;
      end else begin
        state_d = SEND;
        shreg_d = con_out;
        bit_d   = '0;
        byte_d  = '0;
      end
      SEND: begin
        pend_d = pend_q | abort;
        if (bit_q != 4'd9) bit_d = bit_q + 4'd1;
        else begin
          bit_d = '0;
          if (last) words_d = words_q + (ADDR_BITS+1)'(1);
          // an abort lets the frame on the wire finish, then stops at its stop bit
          if (pend_d) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end else if (last) begin
            state_d = addr_q == end_q ? DONE : READ;
            addr_d  = addr_q == end_q ? addr_q : addr_q + ADDR_BITS'(1);
          end else begin
            byte_d  = byte_q + BB'(1);
            shreg_d = shreg_q >> 8;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // tx is registered from the next-cycle frame position so it never glitches from inputs
  assign cur_byte = shreg_d[7:0];
  assign bsel     = 3'(bit_d - 4'd1);
  assign tx_d     = state_d != SEND ? 1'b1 : bit_d == 4'd0 ? 1'b0 : bit_d == 4'd9 ? 1'b1 : cur_byte[bsel];
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      end_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      words_q   <= '0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      end_q     <= end_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      words_q   <= words_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
      tx_q      <= tx_d;
    end
  end
endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Sequencer that walks an inclusive address range of data memory through the read-only consistency port (con_addr/con_out) and streams every word out as 8N1 UART frames, one bit per uart_clk cycle. It sits between the core's data-memory debug port and the board TX pin (ck_io7). It lets post-run memory contents be checked off-chip against the answer key, without a simulator hierarchy reference. It owns the read port exclusively while busy.

## Interface
- ADDR_BITS, 10, width of con_addr (matches DATAMEM_BITS)
- WORD_WIDTH, 32, width of con_out; must be a multiple of 8
- uart_clk  in  1  bit-rate clock (115.2 kHz); all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- start  in  1  begin dump; sampled only in IDLE
- abort  in  1  stop dump after the current frame's stop bit
- start_addr  in  ADDR_BITS  first address, inclusive
- end_addr  in  ADDR_BITS  last address, inclusive
- con_rd  out  1  read strobe to data memory
- con_addr  out  ADDR_BITS  read address
- con_out  in  WORD_WIDTH  read data, valid 1 cycle after con_rd
- tx  out  1  serial line, idle high
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle completion pulse
- aborted  out  1  high with done if the dump ended via abort; held until next start
- words_sent  out  ADDR_BITS+1  count of fully transmitted words, held after done

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: tx=1, con_rd=0, busy=0. start=1 latches start_addr/end_addr into internal regs, clears words_sent and aborted, and goes to READ.
- READ: con_rd=1, con_addr=current address. Next state is CAPTURE.
- CAPTURE: con_rd=0. con_out is loaded into the word shift register. Next state is SEND.
- SEND: WORD_WIDTH/8 frames, back to back, least significant byte first.
  - Each frame is 10 cycles: start bit 0, data bits d0..d7 LSB first, stop bit 1.
  - After the last stop bit, words_sent increments.
  - If the current address equals the latched end_addr, go to DONE. Otherwise the address becomes (address+1) mod 2^ADDR_BITS and the state goes to READ.
- Wrap-around: if end_addr < start_addr, the walk passes through 2^ADDR_BITS−1 and continues at 0. Word count N = ((end−start) mod 2^ADDR_BITS)+1. start_addr==end_addr gives exactly one word.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- abort is sampled in READ, CAPTURE and SEND.
  - In READ or CAPTURE: go to DONE on the next edge and send nothing further.
  - In SEND: finish the current frame through its stop bit, then go to DONE. The partial word does not count in words_sent.
  - aborted=1 in both cases.
- start while busy is ignored. start and abort asserted together in IDLE: start wins, abort is ignored.
- Changes to start_addr/end_addr while busy have no effect.
- Reset at any point: next edge has tx=1, con_rd=0, con_addr=0, busy=0, done=0, aborted=0, words_sent=0, state IDLE. A frame in flight is truncated.

## Timing
- Reset values: tx=1, con_rd=0, con_addr=0, busy=0, done=0, aborted=0, words_sent=0.
- Start accepted at edge E: READ occupies cycle E+1, CAPTURE E+2. The first start bit is on tx in cycle E+3.
- Per word: 2 + 5·WORD_WIDTH/4 cycles (42 at WORD_WIDTH=32).
- done is high in cycle E+1+42·N for an unaborted dump. busy is high in cycles E+1 .. E+42·N.
- Memory read latency is fixed at 1 cycle. con_out is sampled only in CAPTURE.
- tx is registered; no combinational path from any input to tx.
- Two dumps with a single-cycle start after done: the minimum gap is 1 IDLE cycle with tx high.

## Test plan
- Single word: start_addr=end_addr=0x004, mem[4]=0xDEADBEEF, start pulse.
  - tx carries frames 0xEF, 0xBE, 0xAD, 0xDE, each 0, LSB-first bits, 1.
  - done pulses 42 cycles after busy rises; words_sent=1.
- Range: start_addr=0x010, end_addr=0x013.
  - con_addr sequence is 0x010..0x013, one con_rd pulse per word.
  - 16 frames total; done at E+169; words_sent=4.
- Wrap: start_addr=0x3FE, end_addr=0x001.
  - Reads 0x3FE, 0x3FF, 0x000, 0x001; words_sent=4.
- Abort in the 2nd frame of word 2 of a 4-word dump.
  - That frame completes with its stop bit; no further start bits.
  - done and aborted both 1; words_sent=1.
- Reset mid-frame (nrst=0 for 1 cycle during a data bit).
  - All outputs return to reset values on the next edge; tx stays 1.
  - A new start afterwards dumps normally.
- start pulsed again while busy, and start+abort together in IDLE.
  - The second start is ignored; dump length is unchanged.
  - The simultaneous case starts the dump with aborted=0.
